// File: rtl/fifo_drain_pkg.sv
// ============================================================================
// Module  : fifo_drain_pkg
// Brief   : Shared types and constants for the FIFO read-drain block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        FULL   = 2'd3
    } drain_state_t;

    localparam int c_pkt_len_default = 16;
    localparam int c_stat_width      = 16;

endpackage

`default_nettype wire

// File: rtl/drain_skid_buf.sv
// ============================================================================
// Module  : drain_skid_buf
// Brief   : Two-entry in-order skid buffer; head is a register, not a mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module drain_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    // Caller guarantees push at occ==2 only together with pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else if (clr) begin
            r_occ <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (push) begin
                        r_head <= din;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        r_head <= din;
                    end else if (push) begin
                        r_tail <= din;
                        r_occ  <= 2'd2;
                    end else if (pop) begin
                        r_occ <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        r_head <= r_tail;
                        if (push) begin
                            r_tail <= din;
                        end else begin
                            r_occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign occ  = r_occ;
    assign head = r_head;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_drain.sv
// ============================================================================
// Module  : fifo_rd_drain
// Brief   : Drains a FIFO into a valid/ready stream with packet framing.
//           Optional beat statistics enabled by macro FIFO_DRAIN_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fifo_rd_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int PKT_LEN    = c_pkt_len_default
) (
    input  logic                    rd_clk,
    input  logic                    rst,
    input  logic                    empty,
    input  logic                    underflow,
    input  logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rd_en,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    err_underflow,
    output logic [c_stat_width-1:0] stat_beats
);

    localparam logic [15:0] c_last_idx = 16'(PKT_LEN - 1);

    drain_state_t r_state;
    drain_state_t w_state_next;
    logic         r_inf;
    logic [1:0]   w_occ;
    logic [1:0]   w_occ_next;
    logic         w_pop;
    logic         w_push;
    logic         w_rd_en;
    logic [15:0]  r_beat_idx;
    logic         r_err;

    assign w_pop  = out_valid && out_ready;
    // A word landing in the flush cycle belongs to the discarded stream.
    assign w_push = r_inf && !flush;

    always_comb begin
        w_rd_en = 1'b0;
        if (!rst && !empty && !flush) begin
            w_rd_en = (({1'b0, w_occ} + {2'b00, r_inf}) - {2'b00, w_pop}) < 3'd2;
        end
    end

    always_comb begin
        w_occ_next   = w_occ;
        w_state_next = r_state;
        if (flush) begin
            w_occ_next   = 2'd0;
            w_state_next = IDLE;
        end else begin
            w_occ_next = (w_occ + {1'b0, w_push}) - {1'b0, w_pop};
            case (w_occ_next)
                2'd0:    w_state_next = w_rd_en ? FILL : IDLE;
                2'd1:    w_state_next = STREAM;
                default: w_state_next = FULL;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_inf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_inf   <= w_rd_en;
        end
    end

    drain_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk  (rd_clk),
        .rst  (rst),
        .clr  (flush),
        .push (w_push),
        .pop  (w_pop),
        .din  (rdata),
        .occ  (w_occ),
        .head (out_data)
    );

    always_ff @(posedge rd_clk) begin
        if (rst || flush) begin
            r_beat_idx <= 16'd0;
        end else if (w_pop) begin
            r_beat_idx <= (r_beat_idx == c_last_idx) ? 16'd0 : r_beat_idx + 16'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (underflow) begin
            r_err <= 1'b1;
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [c_stat_width-1:0] r_stat;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_stat <= '0;
        end else if (w_pop && (r_stat != {c_stat_width{1'b1}})) begin
            r_stat <= r_stat + {{(c_stat_width-1){1'b0}}, 1'b1};
        end
    end

    assign stat_beats = r_stat;
`else
    assign stat_beats = '0;
`endif

    assign rd_en         = w_rd_en;
    assign out_valid     = (r_state == STREAM) || (r_state == FULL);
    assign out_last      = out_valid && (r_beat_idx == c_last_idx);
    assign err_underflow = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
// ============================================================================
// Module  : tb_fifo_rd_drain
// Brief   : Directed bench with a queue-based stream model checked every cycle.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_fifo_rd_drain;

    localparam int DW = `DATA_WIDTH;
    localparam int PL = 4;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic          empty = 1'b1;
    logic          underflow = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rd_en;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err_underflow;
    logic [15:0]   stat_beats;

    int checks = 0;
    int errors = 0;

    fifo_rd_drain #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PL)
    ) dut (
        .rd_clk        (rd_clk),
        .rst           (rst),
        .empty         (empty),
        .underflow     (underflow),
        .rdata         (rdata),
        .rd_en         (rd_en),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .err_underflow (err_underflow),
        .stat_beats    (stat_beats)
    );

    always #5 rd_clk = ~rd_clk;

    // Source FIFO contents and the stream model
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] m_buf[$];
    bit            m_pend = 1'b0;
    logic [DW-1:0] m_pend_word = '0;
    int            m_beats = 0;
    bit            m_err = 1'b0;
    int            m_stat = 0;
    bit            rd_seen = 1'b0;
    bit            chk_en = 1'b0;
    int            cyc = 0;

    bit            log_v  [4096];
    bit            log_l  [4096];
    bit            log_rd [4096];
    logic [DW-1:0] log_d  [4096];

    function automatic int li(int c);
        return c % 4096;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge rd_clk) begin
        bit e_valid;
        bit e_pop;
        bit e_rd;
        e_valid = (m_buf.size() > 0);
        e_pop   = e_valid && out_ready;
        e_rd    = !rst && !empty && !flush &&
                  ((m_buf.size() + int'(m_pend) - int'(e_pop)) < 2);
        if (chk_en) begin
            chk("rd_en", 32'(rd_en), 32'(e_rd));
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("out_last", 32'(out_last), 32'(e_valid && (m_beats == PL - 1)));
            chk("err_underflow", 32'(err_underflow), 32'(m_err));
            chk("stat_beats", 32'(stat_beats), 32'(m_stat));
            if (e_valid) chk("out_data", 32'(out_data), 32'(m_buf[0]));
        end
        log_v[li(cyc)]  = out_valid;
        log_l[li(cyc)]  = out_last;
        log_rd[li(cyc)] = rd_en;
        log_d[li(cyc)]  = out_data;
        rd_seen = rd_en;
        if (rst) begin
            m_buf.delete();
            m_pend  = 1'b0;
            m_beats = 0;
            m_err   = 1'b0;
            m_stat  = 0;
        end else begin
`ifdef FIFO_DRAIN_STATS_EN
            if (e_pop && m_stat < 65535) m_stat++;
`endif
            if (flush) begin
                m_buf.delete();
                m_pend  = 1'b0;
                m_beats = 0;
            end else begin
                if (e_pop) begin
                    void'(m_buf.pop_front());
                    m_beats = (m_beats + 1) % PL;
                end
                if (m_pend) m_buf.push_back(m_pend_word);
                m_pend = e_rd;
                if (e_rd) m_pend_word = src_q[0];
            end
            if (underflow) m_err = 1'b1;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
        if (rd_seen && src_q.size() > 0) rdata = src_q.pop_front();
        empty = (src_q.size() == 0);
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic load(logic [DW-1:0] w);
        src_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        underflow = 1'b0;
        src_q.delete();
        empty = 1'b1;
        tick();
        @(negedge rd_clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        int t1;
        int n;
        tick();
        chk_en = 1'b1;

        // Three words with sink always ready
        do_reset();
        load(8'hA1); load(8'hA2); load(8'hA3);
        out_ready = 1'b1;
        t0 = cyc;
        ticks(6);
        chk("first_rd", 32'(log_rd[li(t0)]), 32'd1);
        chk("lat_gap", 32'(log_v[li(t0 + 1)]), 32'd0);
        chk("beat_a1", 32'({log_v[li(t0 + 2)], log_d[li(t0 + 2)]}), 32'({1'b1, 8'hA1}));
        chk("beat_a2", 32'({log_v[li(t0 + 3)], log_d[li(t0 + 3)]}), 32'({1'b1, 8'hA2}));
        chk("beat_a3", 32'({log_v[li(t0 + 4)], log_d[li(t0 + 4)]}), 32'({1'b1, 8'hA3}));
        chk("drained", 32'(log_v[li(t0 + 5)]), 32'd0);

        // Backpressure: buffer fills to two, head held
        do_reset();
        for (int i = 1; i <= 5; i++) load(DW'(8'hB0 + i));
        t0 = cyc;
        ticks(8);
        n = 0;
        for (int k = 0; k < 8; k++) n += int'(log_rd[li(t0 + k)]);
        chk("bp_rd_count", 32'(n), 32'd2);
        n = 0;
        for (int k = 2; k < 8; k++) n += int'(log_v[li(t0 + k)] && log_d[li(t0 + k)] == 8'hB1);
        chk("bp_head_stable", 32'(n), 32'd6);
        chk("bp_src_left", 32'(src_q.size()), 32'd3);

        // Flush while full, then refill from the remaining words
        flush = 1'b1;
        t1 = cyc;
        tick();
        flush = 1'b0;
        ticks(5);
        chk("full_flush_gone", 32'(log_v[li(t1 + 1)]), 32'd0);
        chk("full_flush_next", 32'({log_v[li(t1 + 3)], log_d[li(t1 + 3)]}), 32'({1'b1, 8'hB3}));

        // Packet framing over 8 beats
        do_reset();
        for (int i = 0; i < 8; i++) load(DW'(8'h10 + i));
        out_ready = 1'b1;
        t0 = cyc;
        ticks(11);
        n = 0;
        for (int k = 0; k < 8; k++)
            n += int'(log_l[li(t0 + 2 + k)] != ((k == 3) || (k == 7)));
        chk("last_pattern_errs", 32'(n), 32'd0);
        chk("last_count", 32'(int'(log_l[li(t0 + 5)]) + int'(log_l[li(t0 + 9)])), 32'd2);

        // Flush mid-stream with a read in flight
        do_reset();
        for (int i = 0; i < 12; i++) load(DW'(8'h20 + i));
        out_ready = 1'b1;
        ticks(4);
        flush = 1'b1;
        out_ready = 1'b0;
        t1 = cyc;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        ticks(8);
        chk("mid_flush_v1", 32'(log_v[li(t1 + 1)]), 32'd0);
        chk("mid_flush_v2", 32'(log_v[li(t1 + 2)]), 32'd0);
        chk("mid_flush_next", 32'({log_v[li(t1 + 3)], log_d[li(t1 + 3)]}), 32'({1'b1, 8'h24}));
        chk("mid_flush_nolast", 32'(log_l[li(t1 + 4)]), 32'd0);
        chk("mid_flush_last", 32'(log_l[li(t1 + 6)]), 32'd1);

        // Sticky underflow
        underflow = 1'b1;
        tick();
        underflow = 1'b0;
        chk("uf_set", 32'(err_underflow), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("uf_after_flush", 32'(err_underflow), 32'd1);
        rst = 1'b1;
        tick();
        chk("uf_after_rst", 32'(err_underflow), 32'd0);

        // Long stream exercising stat saturation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 70010; i++) begin
            if (src_q.size() < 4) load(DW'(i));
            tick();
        end
`ifdef FIFO_DRAIN_STATS_EN
        chk("stat_saturated", 32'(stat_beats), 32'h0000FFFF);
`else
        chk("stat_absent", 32'(stat_beats), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
